aes128_rkey_store: RTL and testbench

- Controller and storage for the full AES-128 key schedule.
- Accepts a cipher key through a valid/ready handshake. Sequences the round-key expansion stage through rounds 0..9, using that stage's rkey_en/round_num/cipher_key inputs and its registered round_key_out.
- Captures all 11 round keys (slot 0 = cipher key, slots 1..10 = round keys) in an internal register file.
- Serves any slot by index with 1-cycle latency. Cipher and inverse-cipher datapaths can therefore read keys in forward or reverse order without re-expanding.

---
 rtl/aes128_rkey_store.sv | 141 ++++++++++++++
 tb/tb_aes128_rkey_store.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_rkey_store.sv
// AES-128 round-key store: sequences the expansion stage and serves any slot.
// Optional zeroize port enabled by defining AES128_RKEY_ZEROIZE_EN.
module aes128_rkey_store #(
   parameter int NUM_RK = 11,
   parameter int KEY_W  = 128
) (
   input  logic             clk_sys,
   input  logic             rst_n,
   input  logic             key_load_valid,
   output logic             key_load_ready,
   input  logic [KEY_W-1:0] cipher_key,
   output logic             exp_rkey_en,
   output logic [3:0]       exp_round_num,
   output logic [KEY_W-1:0] exp_cipher_key,
   input  logic [KEY_W-1:0] round_key_in,
   output logic             key_valid,
   input  logic             rd_en,
   input  logic [3:0]       rd_idx,
   output logic [KEY_W-1:0] rd_key,
   output logic             rd_valid,
   output logic             rd_err
`ifdef AES128_RKEY_ZEROIZE_EN
   ,
   input  logic             zeroize
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      READY
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0]       rnum_q, rnum_d;
   logic             kv_q, kv_d;
   logic [KEY_W-1:0] slot_q [NUM_RK];
   logic [KEY_W-1:0] rd_key_q;
   logic             rd_valid_q;
   logic             rd_err_q;
   logic             zero_w;
   logic             load_w;
   logic             rd_ok_w;
   logic             rd_bad_w;

`ifdef AES128_RKEY_ZEROIZE_EN
   assign zero_w = zeroize;
`else
   assign zero_w = 1'b0;
`endif

   assign key_load_ready = (state_q != EXPAND) & ~zero_w;
   assign load_w         = key_load_valid & key_load_ready;
   assign exp_rkey_en    = (state_q == EXPAND) & (cnt_q <= 4'd9);
   assign exp_round_num  = rnum_q;
   assign exp_cipher_key = slot_q[0];
   assign key_valid      = kv_q;
   assign rd_key         = rd_key_q;
   assign rd_valid       = rd_valid_q;
   assign rd_err         = rd_err_q;

   assign rd_ok_w  = rd_en & kv_q & (rd_idx <= 4'd10);
   assign rd_bad_w = rd_en & ~rd_ok_w;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rnum_d  = rnum_q;
      kv_d    = kv_q;
      unique case (state_q)
         IDLE, READY: begin
            if (load_w) begin
               state_d = EXPAND;
               cnt_d   = 4'd0;
               rnum_d  = 4'd0;
               kv_d    = 1'b0;
            end
         end
         EXPAND: begin
            if (cnt_q == 4'd10) begin
               state_d = READY;
               cnt_d   = 4'd0;
               rnum_d  = 4'd0;
               kv_d    = 1'b1;
            end else begin
               cnt_d  = cnt_q + 4'd1;
               rnum_d = (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (zero_w) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
         rnum_d  = 4'd0;
         kv_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rnum_q  <= 4'd0;
         kv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rnum_q  <= rnum_d;
         kv_q    <= kv_d;
      end
   end

   // round_key_in lags round_num by one cycle, so at cnt it holds key cnt
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_RK; i++) slot_q[i] <= '0;
      end else if (zero_w) begin
         for (int i = 0; i < NUM_RK; i++) slot_q[i] <= '0;
      end else begin
         if (load_w) slot_q[0] <= cipher_key;
         if (state_q == EXPAND && cnt_q != 4'd0)
            slot_q[cnt_q] <= round_key_in;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         rd_key_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         rd_valid_q <= rd_ok_w;
         rd_err_q   <= rd_bad_w;
         if (zero_w)       rd_key_q <= '0;
         else if (rd_ok_w) rd_key_q <= slot_q[rd_idx];
      end
   end

endmodule

// File: tb/tb_aes128_rkey_store.sv
// Directed bench for aes128_rkey_store with a table-driven expansion stage.
// Zeroize scenario runs only when AES128_RKEY_ZEROIZE_EN is defined.
module tb_aes128_rkey_store;

   localparam logic [127:0] KA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KB = 128'h000102030405060708090a0b0c0d0e0f;

   logic         clk_sys = 1'b0;
   logic         rst_n;
   logic         key_load_valid;
   logic         key_load_ready;
   logic [127:0] cipher_key;
   logic         exp_rkey_en;
   logic [3:0]   exp_round_num;
   logic [127:0] exp_cipher_key;
   logic [127:0] round_key_in;
   logic         key_valid;
   logic         rd_en;
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;
   logic         rd_valid;
   logic         rd_err;
`ifdef AES128_RKEY_ZEROIZE_EN
   logic         zeroize;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   aes128_rkey_store dut (
      .clk_sys        (clk_sys),
      .rst_n          (rst_n),
      .key_load_valid (key_load_valid),
      .key_load_ready (key_load_ready),
      .cipher_key     (cipher_key),
      .exp_rkey_en    (exp_rkey_en),
      .exp_round_num  (exp_round_num),
      .exp_cipher_key (exp_cipher_key),
      .round_key_in   (round_key_in),
      .key_valid      (key_valid),
      .rd_en          (rd_en),
      .rd_idx         (rd_idx),
      .rd_key         (rd_key),
      .rd_valid       (rd_valid),
      .rd_err         (rd_err)
`ifdef AES128_RKEY_ZEROIZE_EN
      ,
      .zeroize        (zeroize)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   // FIPS-197 A.1 (key A) and C.1 (key B) round keys
   function automatic logic [127:0] rk(input logic b, input int i);
      logic [127:0] r;
      r = '0;
      if (!b) begin
         case (i)
            0:  r = KA;
            1:  r = 128'ha0fafe1788542cb123a339392a6c7605;
            2:  r = 128'hf2c295f27a96b9435935807a7359f67f;
            3:  r = 128'h3d80477d4716fe3e1e237e446d7a883b;
            4:  r = 128'hef44a541a8525b7fb671253bdb0bad00;
            5:  r = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            6:  r = 128'h6d88a37a110b3efddbf98641ca0093fd;
            7:  r = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            8:  r = 128'head27321b58dbad2312bf5607f8d292f;
            9:  r = 128'hac7766f319fadc2128d12941575c006e;
            10: r = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            default: r = '0;
         endcase
      end else begin
         case (i)
            0:  r = KB;
            1:  r = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
            2:  r = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
            3:  r = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
            4:  r = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
            5:  r = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
            6:  r = 128'h5e390f7df7a69296a7553dc10aa31f6b;
            7:  r = 128'h14f9701ae35fe28c440adf4d4ea9c026;
            8:  r = 128'h47438735a41c65b9e016baf4aebf7ad2;
            9:  r = 128'h549932d1f08557681093ed9cbe2c974e;
            10: r = 128'h13111d7fe3944a17f307a78b4d2b30c5;
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   // expansion stage: registered output = round key (round_num+1)
   always @(posedge clk_sys) begin
      if (exp_rkey_en) begin
         if (exp_cipher_key == KA)
            round_key_in <= rk(1'b0, int'(exp_round_num) + 1);
         else if (exp_cipher_key == KB)
            round_key_in <= rk(1'b1, int'(exp_round_num) + 1);
         else
            round_key_in <= '0;
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_tests++;
      if (key_valid !== 1'b0 || rd_valid !== 1'b0 || rd_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: kv=%b rv=%b re=%b want 0 0 0",
                  key_valid, rd_valid, rd_err);
      end
      n_tests++;
      if (exp_rkey_en !== 1'b0 || exp_round_num !== 4'd0 ||
          rd_key !== '0 || exp_cipher_key !== '0) begin
         n_fail++;
         $display("FAIL reset_data: en=%b rn=%0d rk=%h ck=%h want zeros",
                  exp_rkey_en, exp_round_num, rd_key, exp_cipher_key);
      end
      n_tests++;
      if (key_load_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b want 1", key_load_ready);
      end
      rst_n = 1'b1;
      tick();
   endtask

   // handshake cycle is T0; key_valid must be low through T0+11, high at T0+12
   task automatic run_load(input logic [127:0] k, input string nm);
      int bad_en;
      int bad_rdy;
      bad_en  = 0;
      bad_rdy = 0;
      cipher_key     = k;
      key_load_valid = 1'b1;
      n_tests++;
      if (key_load_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ready_t0: got %b want 1", nm, key_load_ready);
      end
      tick();
      key_load_valid = 1'b0;
      n_tests++;
      if (exp_cipher_key !== k) begin
         n_fail++;
         $display("FAIL %s_exp_key: got %h want %h", nm, exp_cipher_key, k);
      end
      for (int c = 0; c < 10; c++) begin
         if (exp_rkey_en !== 1'b1 || exp_round_num !== 4'(c)) bad_en++;
         if (key_load_ready !== 1'b0 || key_valid !== 1'b0) bad_rdy++;
         tick();
      end
      if (exp_rkey_en !== 1'b0 || exp_round_num !== 4'd0) bad_en++;
      if (key_load_ready !== 1'b0 || key_valid !== 1'b0) bad_rdy++;
      n_tests++;
      if (bad_en != 0) begin
         n_fail++;
         $display("FAIL %s_round_seq: %0d bad cycles want 0", nm, bad_en);
      end
      n_tests++;
      if (bad_rdy != 0) begin
         n_fail++;
         $display("FAIL %s_busy: %0d bad cycles want 0", nm, bad_rdy);
      end
      tick();
      n_tests++;
      if (key_valid !== 1'b1 || key_load_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_kv_t12: kv=%b rdy=%b want 1 1",
                  nm, key_valid, key_load_ready);
      end
   endtask

   task automatic test_load_a();
      run_load(KA, "loadA");
   endtask

   task automatic test_read_basic();
      int idx[3] = '{0, 1, 10};
      for (int i = 0; i < 3; i++) begin
         rd_en  = 1'b1;
         rd_idx = 4'(idx[i]);
         tick();
         rd_en = 1'b0;
         n_tests++;
         if (rd_valid !== 1'b1 || rd_err !== 1'b0 ||
             rd_key !== rk(1'b0, idx[i])) begin
            n_fail++;
            $display("FAIL read_idx%0d: v=%b e=%b key=%h want 1 0 %h",
                     idx[i], rd_valid, rd_err, rd_key, rk(1'b0, idx[i]));
         end
         tick();
         n_tests++;
         if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_pulse%0d: rd_valid=%b want 0", idx[i], rd_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      bad = 0;
      for (int i = 10; i >= 0; i--) begin
         rd_en  = 1'b1;
         rd_idx = 4'(i);
         tick();
         if (rd_valid !== 1'b1 || rd_key !== rk(1'b0, i)) begin
            bad++;
            $display("FAIL sweep_idx%0d: v=%b key=%h want 1 %h",
                     i, rd_valid, rd_key, rk(1'b0, i));
         end
      end
      rd_en = 1'b0;
      n_tests++;
      if (bad != 0) n_fail++;
   endtask

   task automatic test_bad_idx();
      rd_en  = 1'b1;
      rd_idx = 4'd11;
      tick();
      rd_en = 1'b0;
      n_tests++;
      if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_key !== KA) begin
         n_fail++;
         $display("FAIL bad_idx: e=%b v=%b key=%h want 1 0 %h",
                  rd_err, rd_valid, rd_key, KA);
      end
      tick();
      n_tests++;
      if (rd_err !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_idx_pulse: rd_err=%b want 0", rd_err);
      end
   endtask

   task automatic test_second_key();
      int bad_rdy;
      int bad_rd;
      bad_rdy = 0;
      bad_rd  = 0;
      cipher_key     = KB;
      key_load_valid = 1'b1;
      rd_en          = 1'b1;
      rd_idx         = 4'd10;
      tick();
      key_load_valid = 1'b0;
      n_tests++;
      if (rd_valid !== 1'b1 || rd_key !== rk(1'b0, 10)) begin
         n_fail++;
         $display("FAIL collide_read: v=%b key=%h want 1 %h",
                  rd_valid, rd_key, rk(1'b0, 10));
      end
      for (int c = 0; c < 11; c++) begin
         if (key_load_ready !== 1'b0) bad_rdy++;
         rd_idx = 4'(c);
         tick();
         if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_key !== rk(1'b0, 10))
            bad_rd++;
      end
      rd_en = 1'b0;
      n_tests++;
      if (bad_rdy != 0) begin
         n_fail++;
         $display("FAIL keyB_busy: %0d ready cycles want 0", bad_rdy);
      end
      n_tests++;
      if (bad_rd != 0) begin
         n_fail++;
         $display("FAIL read_in_expand: %0d accepted want 0", bad_rd);
      end
      n_tests++;
      if (key_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL keyB_kv: got %b want 1", key_valid);
      end
      for (int i = 0; i <= 10; i += 10) begin
         rd_en  = 1'b1;
         rd_idx = 4'(i);
         tick();
         rd_en = 1'b0;
         n_tests++;
         if (rd_valid !== 1'b1 || rd_key !== rk(1'b1, i)) begin
            n_fail++;
            $display("FAIL keyB_slot%0d: v=%b key=%h want 1 %h",
                     i, rd_valid, rd_key, rk(1'b1, i));
         end
      end
   endtask

   task automatic test_reset_mid_expand();
      cipher_key     = KA;
      key_load_valid = 1'b1;
      tick();
      key_load_valid = 1'b0;
      repeat (5) tick();
      n_tests++;
      if (exp_round_num !== 4'd5 || exp_rkey_en !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_rst_cnt: rn=%0d en=%b want 5 1",
                  exp_round_num, exp_rkey_en);
      end
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if (key_valid !== 1'b0 || exp_rkey_en !== 1'b0 ||
          exp_round_num !== 4'd0 || rd_key !== '0 ||
          rd_valid !== 1'b0 || rd_err !== 1'b0 ||
          exp_cipher_key !== '0 || key_load_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL async_rst: kv=%b en=%b rn=%0d rk=%h rdy=%b want 0 0 0 0 1",
                  key_valid, exp_rkey_en, exp_round_num, rd_key, key_load_ready);
      end
      #1 rst_n = 1'b1;
      tick();
      run_load(KA, "reload");
      rd_en  = 1'b1;
      rd_idx = 4'd10;
      tick();
      rd_en = 1'b0;
      n_tests++;
      if (rd_valid !== 1'b1 || rd_key !== rk(1'b0, 10)) begin
         n_fail++;
         $display("FAIL reload_slot10: v=%b key=%h want 1 %h",
                  rd_valid, rd_key, rk(1'b0, 10));
      end
   endtask

`ifdef AES128_RKEY_ZEROIZE_EN
   task automatic test_zeroize();
      zeroize        = 1'b1;
      key_load_valid = 1'b1;
      cipher_key     = KB;
      #1;
      n_tests++;
      if (key_load_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_ready: got %b want 0", key_load_ready);
      end
      tick();
      zeroize        = 1'b0;
      key_load_valid = 1'b0;
      n_tests++;
      if (key_valid !== 1'b0 || rd_key !== '0 || exp_cipher_key !== '0 ||
          exp_rkey_en !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_clear: kv=%b rk=%h ck=%h en=%b want zeros",
                  key_valid, rd_key, exp_cipher_key, exp_rkey_en);
      end
      rd_en  = 1'b1;
      rd_idx = 4'd0;
      tick();
      rd_en = 1'b0;
      n_tests++;
      if (rd_err !== 1'b1 || rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_read: e=%b v=%b want 1 0", rd_err, rd_valid);
      end
   endtask
`endif

   initial begin
      rst_n          = 1'b0;
      key_load_valid = 1'b0;
      cipher_key     = '0;
      rd_en          = 1'b0;
      rd_idx         = 4'd0;
      round_key_in   = '0;
`ifdef AES128_RKEY_ZEROIZE_EN
      zeroize        = 1'b0;
`endif
      test_reset();
      test_load_a();
      test_read_basic();
      test_back_to_back();
      test_bad_idx();
      test_second_key();
      test_reset_mid_expand();
`ifdef AES128_RKEY_ZEROIZE_EN
      test_zeroize();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
